div3_arbiter: RTL and testbench

Round-robin arbiter sharing one combinational divisibility-by-3 checker among `N_REQ` requesters. Each requester offers a 16-bit number with a valid/ready handshake. The block grants one requester, registers the checker result, and presents it on a single response port tagged with the requester ID. It sits between the client blocks and the shared checker, and is the only path to it.

---
 rtl/div3_pkg.sv | 30 +++
 rtl/div3_core.sv | 26 ++
 rtl/div3_arbiter.sv | 98 +++++++++
 tb/tb_div3_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
// Shared types and helpers for the divisible-by-3 arbiter.
// Round-robin pick is sized for the largest supported requester count.
package div3_pkg;

    localparam int NUM_W = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic {IDLE, RESP} div3_state_t;

    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         last,
        input int                 n
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && valid[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/div3_core.sv
// Combinational divisibility-by-3 checker.
// Even bits weigh 1 mod 3, odd bits weigh -1 mod 3.
module div3_core
    import div3_pkg::*;
(
    input  logic [NUM_W-1:0] number,
    output logic             is_div3
);

    logic [3:0]        even_sum;
    logic [3:0]        odd_sum;
    logic signed [4:0] diff;

    always_comb begin
        even_sum = '0;
        odd_sum  = '0;
        for (int i = 0; i < NUM_W; i += 2) begin
            even_sum = even_sum + 4'(number[i]);
            odd_sum  = odd_sum + 4'(number[i+1]);
        end
        diff = $signed({1'b0, even_sum}) - $signed({1'b0, odd_sum});
        // diff spans -8..8, so only these multiples of 3 are reachable
        is_div3 = diff inside {-5'sd6, -5'sd3, 5'sd0, 5'sd3, 5'sd6};
    end

endmodule

// File: rtl/div3_arbiter.sv
// Round-robin arbiter in front of one shared div-by-3 checker.
// Registers the granted operand and result until downstream takes it.
module div3_arbiter
    import div3_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [NUM_W*N_REQ-1:0] req_number,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [NUM_W-1:0]       rsp_number,
    output logic                   rsp_is_div3,
    output logic [15:0]            rsp_count,
    output logic [15:0]            div_count
);

    div3_state_t        state_q;
    div3_state_t        state_d;
    logic [ID_W-1:0]    last_q;
    logic [ID_W-1:0]    grant;
    logic [MAX_REQ-1:0] valid_ext;
    logic [NUM_W-1:0]   sel_number;
    logic               sel_div3;
    logic               any_valid;
    logic               accept;
    logic               retire;

    always_comb begin
        valid_ext = '0;
        valid_ext[N_REQ-1:0] = req_valid;
    end

    assign any_valid  = |req_valid;
    assign grant      = ID_W'(rr_pick(valid_ext, 3'(last_q), N_REQ));
    assign sel_number = req_number[NUM_W*int'(grant) +: NUM_W];

    div3_core u_core (
        .number  (sel_number),
        .is_div3 (sel_div3)
    );

    // rst_n gates the grant so no request is seen as accepted in reset
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid && rst_n) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_d          = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            rsp_id      <= '0;
            rsp_number  <= '0;
            rsp_is_div3 <= 1'b0;
            rsp_count   <= '0;
            div_count   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q      <= grant;
                rsp_id      <= grant;
                rsp_number  <= sel_number;
                rsp_is_div3 <= sel_div3;
            end
            if (retire) begin
                rsp_count <= rsp_count + 16'd1;
                div_count <= div_count + {15'd0, rsp_is_div3};
            end
        end
    end

endmodule

// File: tb/tb_div3_arbiter.sv
// Randomized bench for div3_arbiter against a transaction-level model.
// Checks every cycle on the falling edge, plus literal pins on the model.
module tb_div3_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [16*N-1:0] req_number = '0;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_number;
    logic          rsp_is_div3;
    logic [15:0]   rsp_count;
    logic [15:0]   div_count;
    logic [15:0]   core_n = '0;
    logic          core_d;

    always #5 clk = ~clk;

    div3_arbiter #(.N_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_number  (req_number),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_number  (rsp_number),
        .rsp_is_div3 (rsp_is_div3),
        .rsp_count   (rsp_count),
        .div_count   (div_count)
    );

    div3_core u_core_chk (
        .number  (core_n),
        .is_div3 (core_d)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction-level model: busy flag, last winner, captured response.
    typedef struct {
        int          id;
        logic [15:0] num;
        bit          div;
        int          t;
    } grant_t;

    grant_t      glog[$];
    bit          m_busy;
    int          m_last;
    int          m_id;
    logic [15:0] m_num;
    bit          m_div;
    logic [15:0] m_rc;
    logic [15:0] m_dc;
    int          cyc = 0;
    int          mg;

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_last = N - 1; m_id = 0;
            m_num = 0; m_div = 0; m_rc = 0; m_dc = 0;
        end else begin
            cyc++;
            if (!m_busy) begin
                mg = pick(req_valid, m_last);
                if (mg >= 0) begin
                    m_id   = mg;
                    m_num  = req_number[16*mg +: 16];
                    m_div  = (m_num % 3 == 0);
                    m_last = mg;
                    m_busy = 1;
                    glog.push_back('{mg, m_num, m_div, cyc});
                end
            end else if (rsp_ready) begin
                m_rc = m_rc + 16'd1;
                m_dc = m_dc + 16'(m_div);
                m_busy = 0;
            end
        end
    end

    logic [N-1:0] exp_rdy;
    int           ep;

    always @(negedge clk) begin
        exp_rdy = '0;
        ep = pick(req_valid, m_last);
        if (rst_n && !m_busy && ep >= 0) exp_rdy[ep] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_busy));
        if (m_busy || !rst_n) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_number", 32'(rsp_number), 32'(m_num));
            check("rsp_is_div3", 32'(rsp_is_div3), 32'(m_div));
        end
        check("rsp_count", 32'(rsp_count), 32'(m_rc));
        check("div_count", 32'(div_count), 32'(m_dc));
    end

    task automatic send(input logic [N-1:0] v, input logic [15:0] num);
        int n0;
        bit ok;
        n0 = glog.size();
        req_valid = v;
        for (int i = 0; i < N; i++) req_number[16*i +: 16] = num;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk); #1;
            if (glog.size() > n0) ok = 1;
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic settle();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int fair_exp[6] = '{0, 1, 2, 3, 0, 1};
    logic [15:0] sw_num[5] = '{16'd0, 16'd1, 16'd3, 16'd65535, 16'd65534};
    bit sw_div[5] = '{1, 0, 1, 1, 0};
    logic [15:0] rc0, dc0;
    int core_bad = 0;
    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // fairness straight out of reset: requester 0 first
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_number = {$urandom, $urandom};
        glog.delete();
        repeat (16) begin @(posedge clk); #1; end
        check("fair_count", 32'(glog.size() >= 6), 1);
        for (int k = 0; k < 6; k++)
            if (glog.size() > k) check("fair_id", glog[k].id, fair_exp[k]);
        for (int k = 0; k < 5; k++)
            if (glog.size() > k + 1)
                check("fair_gap", glog[k+1].t - glog[k].t, 2);

        // single requester sweep through the arbiter
        settle();
        glog.delete();
        for (int k = 0; k < 5; k++) send(4'b0010, sw_num[k]);
        for (int k = 0; k < 300; k++) send(4'b0010, 16'(k));
        for (int k = 0; k < 200; k++) send(4'b0010, 16'($urandom));
        for (int k = 0; k < 5; k++)
            if (glog.size() > k) begin
                check("sweep_num", 32'(glog[k].num), 32'(sw_num[k]));
                check("sweep_div", 32'(glog[k].div), 32'(sw_div[k]));
            end
        foreach (glog[k]) check("sweep_id", glog[k].id, 1);

        // exhaustive checker sweep, first few mismatches printed
        settle();
        for (int v = 0; v < 65536; v++) begin
            core_n = 16'(v);
            #1;
            vectors++;
            if (core_d !== (v % 3 == 0)) begin
                miscompares++;
                if (core_bad < 4)
                    $display("FAIL core_div3: n=%0d got %0b expected %0b",
                             v, core_d, (v % 3 == 0));
                core_bad++;
            end
        end

        // backpressure on a response carrying 9
        settle();
        rsp_ready = 1'b0;
        send(4'b0001, 16'd9);
        req_valid = '1;
        rc0 = m_rc;
        dc0 = m_dc;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_number", 32'(rsp_number), 9);
            check("bp_div", 32'(rsp_is_div3), 1);
            check("bp_id", 32'(rsp_id), 0);
            check("bp_ready", 32'(req_ready), 0);
            check("bp_rc_hold", 32'(rsp_count), 32'(rc0));
        end
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        check("bp_rc_inc", 32'(rsp_count), 32'(rc0 + 16'd1));
        check("bp_dc_inc", 32'(div_count), 32'(dc0 + 16'd1));

        // sparse and withdrawn requests
        settle();
        send(4'b1000, 16'd1);
        send(4'b1100, 16'd2);
        send(4'b0100, 16'd4);
        n = glog.size();
        check("sparse_a", glog[n-2].id, 2);
        check("sparse_b", glog[n-1].id, 2);

        // random traffic
        settle();
        for (int k = 0; k < 1500; k++) begin
            req_valid  = N'($urandom);
            req_number = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                req_number[15:0] = 16'(3 * $urandom_range(0, 21845));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        // reset while a response is pending
        settle();
        rsp_ready = 1'b0;
        send(4'b0001, 16'd5);
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_number", 32'(rsp_number), 0);
        check("rst_div", 32'(rsp_is_div3), 0);
        check("rst_rc", 32'(rsp_count), 0);
        check("rst_dc", 32'(div_count), 0);
        check("rst_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        glog.delete();
        send(4'hF, 16'd7);
        if (glog.size() > 0) check("rst_first_grant", glog[0].id, 0);

        // counter wrap from a preloaded 0xFFFF
        settle();
        force dut.rsp_count = 16'hFFFF;
        force dut.div_count = 16'hFFFF;
        m_rc = 16'hFFFF;
        m_dc = 16'hFFFF;
        #1;
        release dut.rsp_count;
        release dut.div_count;
        #1;
        check("wrap_rc_pre", 32'(rsp_count), 32'hFFFF);
        check("wrap_dc_pre", 32'(div_count), 32'hFFFF);
        send(4'b0001, 16'd6);
        req_valid = '0;
        @(posedge clk); #1;
        check("wrap_rc_post", 32'(rsp_count), 0);
        check("wrap_dc_post", 32'(div_count), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
